// File: rtl/chase_pkg.sv
// Shared types, constants and the LED pattern builder for the LED chase engine.
package chase_pkg;

    localparam int N_LED   = 16;
    localparam int POS_W   = $clog2(N_LED);
    localparam int LAP_MOD = 10000;
    localparam int LAP_W   = 14;
    localparam int SW_W    = 8;

    localparam int SW_SPD_LO = 0;
    localparam int SW_SPD_HI = 2;
    localparam int SW_BOUNCE = 3;
    localparam int SW_DIR    = 4;
    localparam int SW_COMET  = 5;

    localparam logic [POS_W-1:0] POS_MIN = 4'd0;
    localparam logic [POS_W-1:0] POS_ONE = 4'd1;
    localparam logic [POS_W-1:0] POS_MAX = 4'd15;
    localparam logic [LAP_W-1:0] LAP_ONE = 14'd1;
    localparam logic [LAP_W-1:0] LAP_MAX = 14'd9999;

    typedef enum logic [1:0] {
        RUN_UP   = 2'd0,
        RUN_DOWN = 2'd1,
        PAUSED   = 2'd2
    } chase_state_t;

    // Head plus optional two-bit tail trailing opposite to the travel direction;
    // the tail wraps in wrap mode and is dropped past either end in bounce mode.
    function automatic logic [N_LED-1:0] build_led(
        input logic [POS_W-1:0] p,
        input logic             up,
        input logic             comet,
        input logic             bounce
    );
        logic [N_LED-1:0] v;
        logic [POS_W:0]   t1;
        logic [POS_W:0]   t2;
        v     = '0;
        v[p]  = 1'b1;
        if (up) begin
            t1 = {1'b0, p} - 5'd1;
            t2 = {1'b0, p} - 5'd2;
        end else begin
            t1 = {1'b0, p} + 5'd1;
            t2 = {1'b0, p} + 5'd2;
        end
        if (comet && (!bounce || !t1[POS_W])) begin
            v[t1[POS_W-1:0]] = 1'b1;
        end else begin
            v = v;
        end
        if (comet && (!bounce || !t2[POS_W])) begin
            v[t2[POS_W-1:0]] = 1'b1;
        end else begin
            v = v;
        end
        return v;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running step prescaler: pulses tick once every period enabled cycles.
module tick_prescaler #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W:0]   cnt_inc_s;
    logic             reload_s;

    // Compare with >= so a shortened period takes effect immediately; period 0 ticks every cycle.
    always_comb begin
        cnt_inc_s = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
        reload_s  = (cnt_inc_s >= {1'b0, period});
        tick      = en & reload_s;
    end

    // Period counter, frozen while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= reload_s ? '0 : cnt_inc_s[CNT_W-1:0];
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/led_chase_engine.sv
// Moving-light pattern generator for the 16 board LEDs with wrap/bounce modes,
// comet tail, freeze control and a 4-digit lap counter.
module led_chase_engine
    import chase_pkg::*;
#(
    parameter int TICK_BASE = 3_125_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stop,
    input  logic [SW_W-1:0]  sw,
    output logic [N_LED-1:0] led,
    output logic [POS_W-1:0] pos,
    output logic [LAP_W-1:0] lap_count,
    output logic             step
);

    localparam int               CNT_W       = $clog2(TICK_BASE + 1);
    localparam logic [CNT_W-1:0] TICK_BASE_W = CNT_W'(TICK_BASE);

    chase_state_t     state_r, state_nxt_s;
    chase_state_t     resume_r, resume_nxt_s;
    chase_state_t     run_nxt_s;
    logic [CNT_W-1:0] period_s;
    logic             tick_s;
    logic             bounce_s;
    logic             lap_inc_s;
    logic [POS_W-1:0] pos_nxt_s;
    logic [N_LED-1:0] led_nxt_s;
    logic [LAP_W-1:0] lap_nxt_s;
    logic             step_nxt_s;
    logic             sw_unused_s;

    assign sw_unused_s = ^sw[7:6];
    assign period_s    = TICK_BASE_W >> sw[SW_SPD_HI:SW_SPD_LO];
    assign bounce_s    = sw[SW_BOUNCE];

    // The prescaler keeps counting during the cycle stop is first seen, so a coincident tick still steps.
    tick_prescaler #(
        .CNT_W (CNT_W)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en     (state_r != PAUSED),
        .period (period_s),
        .tick   (tick_s)
    );

    // Next head position, direction, pattern and lap count on a tick; pause/resume sequencing.
    always_comb begin
        step_nxt_s   = 1'b0;
        pos_nxt_s    = pos;
        led_nxt_s    = led;
        lap_nxt_s    = lap_count;
        lap_inc_s    = 1'b0;
        run_nxt_s    = state_r;
        state_nxt_s  = state_r;
        resume_nxt_s = resume_r;

        if (tick_s) begin
            step_nxt_s = 1'b1;
            if (!bounce_s) begin
                if (sw[SW_DIR]) begin
                    run_nxt_s = RUN_DOWN;
                    pos_nxt_s = pos - POS_ONE;
                    lap_inc_s = (pos == POS_MIN);
                end else begin
                    run_nxt_s = RUN_UP;
                    pos_nxt_s = pos + POS_ONE;
                    lap_inc_s = (pos == POS_MAX);
                end
            end else begin
                case (state_r)
                    RUN_UP: begin
                        if (pos == POS_MAX) begin
                            run_nxt_s = RUN_DOWN;
                            pos_nxt_s = POS_MAX - POS_ONE;
                        end else begin
                            run_nxt_s = RUN_UP;
                            pos_nxt_s = pos + POS_ONE;
                        end
                    end
                    RUN_DOWN: begin
                        if (pos == POS_MIN) begin
                            run_nxt_s = RUN_UP;
                            pos_nxt_s = POS_ONE;
                            lap_inc_s = 1'b1;
                        end else begin
                            run_nxt_s = RUN_DOWN;
                            pos_nxt_s = pos - POS_ONE;
                        end
                    end
                    default: begin
                        run_nxt_s = RUN_UP;
                        pos_nxt_s = pos;
                    end
                endcase
            end
            led_nxt_s = build_led(pos_nxt_s, run_nxt_s == RUN_UP, sw[SW_COMET], bounce_s);
            if (lap_inc_s) begin
                lap_nxt_s = (lap_count == LAP_MAX) ? '0 : lap_count + LAP_ONE;
            end else begin
                lap_nxt_s = lap_count;
            end
        end else begin
            step_nxt_s = 1'b0;
        end

        case (state_r)
            RUN_UP, RUN_DOWN: begin
                if (stop) begin
                    state_nxt_s  = PAUSED;
                    resume_nxt_s = run_nxt_s;
                end else begin
                    state_nxt_s  = run_nxt_s;
                end
            end
            PAUSED: begin
                if (!stop) begin
                    state_nxt_s = resume_r;
                end else begin
                    state_nxt_s = PAUSED;
                end
            end
            default: begin
                state_nxt_s = RUN_UP;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= RUN_UP;
            resume_r  <= RUN_UP;
            pos       <= '0;
            led       <= 16'h0001;
            lap_count <= '0;
            step      <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            resume_r  <= resume_nxt_s;
            pos       <= pos_nxt_s;
            led       <= led_nxt_s;
            lap_count <= lap_nxt_s;
            step      <= step_nxt_s;
        end
    end

endmodule

// File: tb/tb_led_chase_engine.sv
// Directed self-checking bench for led_chase_engine with a short prescaler base.
module tb_led_chase_engine;

    logic        clk;
    logic        reset;
    logic        stop;
    logic [7:0]  sw;
    logic [15:0] led;
    logic [3:0]  pos;
    logic [13:0] lap_count;
    logic        step;

    int n_tests;
    int n_fail;
    int cyc;
    int bad;

    led_chase_engine #(
        .TICK_BASE (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stop      (stop),
        .sw        (sw),
        .led       (led),
        .pos       (pos),
        .lap_count (lap_count),
        .step      (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic [7:0] sw_val);
        reset = 1'b1;
        stop  = 1'b0;
        sw    = sw_val;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Counts negedges until step is seen, bounded by max.
    task automatic wait_step(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step && n < max);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        stop    = 1'b0;
        sw      = 8'h00;

        // Reset values and slowest speed (period 8)
        @(negedge clk);
        check("rst_led", led, 32'h0001);
        check("rst_pos", pos, 32'd0);
        check("rst_lap", lap_count, 32'd0);
        check("rst_step", step, 32'd0);
        do_reset(8'h00);
        wait_step(20, cyc);
        check("first_step_lat", cyc, 32'd8);
        check("first_step_led", led, 32'h0002);
        check("first_step_pos", pos, 32'd1);
        repeat (120) @(negedge clk);
        check("lap128_led", led, 32'h0001);
        check("lap128_lap", lap_count, 32'd1);
        check("lap128_step", step, 32'd1);

        // Period 1: a step every cycle, lap at the wrap
        do_reset(8'h03);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            check("p1_pos", pos, k % 16);
            check("p1_step", step, 32'd1);
            check("p1_lap", lap_count, (k >= 16) ? 32'd1 : 32'd0);
        end

        // Freeze mid-count with the prescaler at 5
        do_reset(8'h00);
        wait_step(20, cyc);
        repeat (5) @(negedge clk);
        stop = 1'b1;
        bad  = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (step !== 1'b0 || pos !== 4'd1 || led !== 16'h0002 || lap_count !== 14'd0) bad++;
        end
        check("stop_hold_bad_cycles", bad, 32'd0);
        stop = 1'b0;
        wait_step(20, cyc);
        check("resume_lat", cyc, 32'd3);
        check("resume_pos", pos, 32'd2);
        check("resume_led", led, 32'h0004);

        // Stop raised in the tick cycle: step completes, then freeze
        repeat (7) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        check("stop_tick_step", step, 32'd1);
        check("stop_tick_pos", pos, 32'd3);
        repeat (10) @(negedge clk);
        check("stop_tick_hold_pos", pos, 32'd3);
        check("stop_tick_hold_step", step, 32'd0);
        stop = 1'b0;
        wait_step(30, cyc);
        check("stop_tick_resume_lat", cyc, 32'd9);
        check("stop_tick_resume_pos", pos, 32'd4);

        // Bounce mode at the top end, then down to a reversal at 0
        do_reset(8'h03);
        repeat (13) @(negedge clk);
        check("b_pre_pos", pos, 32'd13);
        sw = 8'h0B;
        @(negedge clk);
        check("b_pos14", pos, 32'd14);
        check("b_led14", led, 32'h4000);
        @(negedge clk);
        check("b_pos15", pos, 32'd15);
        check("b_led15", led, 32'h8000);
        @(negedge clk);
        check("b_back14", pos, 32'd14);
        check("b_back_led", led, 32'h4000);
        repeat (14) @(negedge clk);
        check("b_pos0", pos, 32'd0);
        check("b_lap0", lap_count, 32'd0);
        sw = 8'h2B;
        @(negedge clk);
        check("b_rev_pos", pos, 32'd1);
        check("b_rev_lap", lap_count, 32'd1);
        check("b_comet_clip1", led, 32'h0003);
        @(negedge clk);
        check("b_comet_clip2", led, 32'h0007);

        // Comet in wrap mode: tail wraps around the top
        do_reset(8'h23);
        @(negedge clk);
        check("comet_wrap_led", led, 32'h8003);
        @(negedge clk);
        check("comet_wrap_led2", led, 32'h0007);

        // Wrap downward from reset, then asynchronous reset mid-run
        do_reset(8'h13);
        @(negedge clk);
        check("down_pos", pos, 32'd15);
        check("down_led", led, 32'h8000);
        check("down_lap", lap_count, 32'd1);
        repeat (3) @(negedge clk);
        check("down_pos12", pos, 32'd12);
        reset = 1'b1;
        #1;
        check("async_rst_led", led, 32'h0001);
        check("async_rst_lap", lap_count, 32'd0);
        check("async_rst_pos", pos, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
